// File: rtl/pipelined_riscv_pkg.sv
// Shared encodings and control-word layouts for the pipelined RISC-V control unit.
package pipelined_riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_RESW = 2'b01,
    FWD_ALUM = 2'b10
  } fwd_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctl_t    alu_ctl;
    logic        alu_src;
  } ctrl_e_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
  } ctrl_w_t;

  // Unlisted func3 values fall back to add; sub_sel is only honoured for func3=000.
  function automatic alu_ctl_t alu_decode(input logic [2:0] f3, input logic sub_sel);
    alu_ctl_t r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  r = ALU_SLT;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipelined_riscv_hazard.sv
// Stall, flush and operand-forwarding decisions from the register tags of the datapath.
module pipelined_riscv_hazard
  import pipelined_riscv_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FORWARD_EN = 1
) (
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic [1:0]        result_src_e,
  input  logic              pc_src_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e
);

  // x0 is hard-wired, so a zero destination never creates a dependency.
  function automatic logic d_reads(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                                   input logic [REG_AW-1:0] rd);
    return (rd != '0) && ((rs1 == rd) || (rs2 == rd));
  endfunction

  function automatic fwd_t fwd_sel(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rdm,
                                   input logic [REG_AW-1:0] rdw, input logic wm, input logic ww);
    fwd_t r;
    r = FWD_RF;
    if (wm && (rdm != '0) && (rs == rdm)) r = FWD_ALUM;
    else if (ww && (rdw != '0) && (rs == rdw)) r = FWD_RESW;
    return r;
  endfunction

  logic lw_stall;
  logic raw_stall;
  logic stall;
  fwd_t fwd_a;
  fwd_t fwd_b;

  always_comb begin
    lw_stall  = (result_src_e == RES_MEM) && d_reads(rs1_d, rs2_d, rd_e);
    raw_stall = 1'b0;
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    if (FORWARD_EN != 0) begin
      fwd_a = fwd_sel(rs1_e, rd_m, rd_w, reg_write_m, reg_write_w);
      fwd_b = fwd_sel(rs2_e, rd_m, rd_w, reg_write_m, reg_write_w);
    end else begin
      // Without bypass paths, every in-flight writer of a D source must drain first.
      raw_stall = (reg_write_e && d_reads(rs1_d, rs2_d, rd_e)) ||
                  (reg_write_m && d_reads(rs1_d, rs2_d, rd_m)) ||
                  (reg_write_w && d_reads(rs1_d, rs2_d, rd_w));
    end
  end

  assign stall       = lw_stall | raw_stall;
  assign stall_f     = stall;
  assign stall_d     = stall;
  assign flush_d     = pc_src_e;
  assign flush_e     = stall | pc_src_e;
  assign forward_a_e = fwd_a;
  assign forward_b_e = fwd_b;

endmodule

// File: rtl/pipelined_riscv_uc.sv
// Control unit for pipelined_riscv_fd: D-stage decoder, E/M/W control registers and hazard unit.
module pipelined_riscv_uc
  import pipelined_riscv_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FORWARD_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic              zeroE,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  output logic [1:0]        ImmSrcD,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic              PCSrcE,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcW,
  output logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  ctrl_e_t  dec_ctrl;
  imm_src_t dec_imm;
  ctrl_e_t  ctrl_e_d, ctrl_e_q;
  ctrl_m_t  ctrl_m_d, ctrl_m_q;
  ctrl_w_t  ctrl_w_d, ctrl_w_q;
  logic     pc_src_e;
  logic     flush_e;
  logic     unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  // D stage: unknown opcodes decode to an all-zero bubble.
  always_comb begin
    dec_ctrl = '0;
    dec_imm  = IMM_I;
    case (opcode)
      OP_LOAD: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.result_src = RES_MEM;
        dec_ctrl.alu_src    = 1'b1;
      end
      OP_STORE: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_imm            = IMM_S;
      end
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_ctl   = alu_decode(func3, func7[5]);
      end
      OP_ITYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_ctl   = alu_decode(func3, 1'b0);
      end
      OP_BRANCH: begin
        dec_ctrl.branch  = 1'b1;
        dec_ctrl.alu_ctl = ALU_SUB;
        dec_imm          = IMM_B;
      end
      OP_JAL: begin
        dec_ctrl.jump       = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.result_src = RES_PC4;
        dec_imm             = IMM_J;
      end
      default: ;
    endcase
  end

  always_comb begin
    ctrl_e_d = dec_ctrl;
    if (flush_e) ctrl_e_d = '0;
    ctrl_m_d = '{reg_write: ctrl_e_q.reg_write, result_src: ctrl_e_q.result_src,
                 mem_write: ctrl_e_q.mem_write};
    ctrl_w_d = '{reg_write: ctrl_m_q.reg_write, result_src: ctrl_m_q.result_src};
  end

  // D->E, E->M, M->W boundaries; M and W never stall or flush.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      ctrl_m_q <= ctrl_m_d;
      ctrl_w_q <= ctrl_w_d;
    end
  end

  assign pc_src_e = (ctrl_e_q.branch & zeroE) | ctrl_e_q.jump;

  pipelined_riscv_hazard #(
    .REG_AW    (REG_AW),
    .FORWARD_EN(FORWARD_EN)
  ) u_hazard (
    .rs1_d       (Rs1D),
    .rs2_d       (Rs2D),
    .rs1_e       (Rs1E),
    .rs2_e       (Rs2E),
    .rd_e        (RdE),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_e (ctrl_e_q.reg_write),
    .reg_write_m (ctrl_m_q.reg_write),
    .reg_write_w (ctrl_w_q.reg_write),
    .result_src_e(ctrl_e_q.result_src),
    .pc_src_e    (pc_src_e),
    .stall_f     (StallF),
    .stall_d     (StallD),
    .flush_d     (FlushD),
    .flush_e     (flush_e),
    .forward_a_e (ForwardAE),
    .forward_b_e (ForwardBE)
  );

  assign FlushE      = flush_e;
  assign ImmSrcD     = dec_imm;
  assign ALUSrcE     = ctrl_e_q.alu_src;
  assign ALUControlE = ctrl_e_q.alu_ctl;
  assign PCSrcE      = pc_src_e;
  assign MemWriteM   = ctrl_m_q.mem_write;
  assign ResultSrcW  = ctrl_w_q.result_src;
  assign RegWriteW   = ctrl_w_q.reg_write;

endmodule
